wired_inst_queue: RTL

Parametrised multi-lane instruction decoupling queue that sits between the frontend package interface and the backend decode stage. It cuts the long frontend→backend handshake path. It accepts a LANES-wide masked package per cycle, compacts the valid lanes into an in-order circular buffer, and presents up to DEQ oldest entries per cycle to the decoder with per-slot handshakes. It generalises the fixed 2-lane package FIFO with configurable enqueue and dequeue widths, lane compaction, partial dequeue, an occupancy output and flush.

---
 rtl/wired_inst_queue_if.sv | 30 +++
 rtl/wired_inst_queue.sv | 91 +++++++++
 2 files changed

// File: rtl/wired_inst_queue_if.sv
// Frontend-package / decoder-slot bundle of the instruction decoupling queue.
// Directional suffixes follow the queue's view: _i into the queue, _o out of it.
interface wired_inst_queue_if #(
  parameter int unsigned LANES      = 2,
  parameter int unsigned DEQ        = 2,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                                flush_i;
  logic                                pkg_valid_i;
  logic                                pkg_ready_o;
  logic [LANES-1:0]                    pkg_mask_i;
  logic [LANES-1:0][DATA_WIDTH-1:0]    pkg_i;
  logic [DEQ-1:0]                      deq_valid_o;
  logic [DEQ-1:0]                      deq_ready_i;
  logic [DEQ-1:0][DATA_WIDTH-1:0]      deq_o;
  logic [CW-1:0]                       count_o;

  modport slave (
    input  flush_i, pkg_valid_i, pkg_mask_i, pkg_i, deq_ready_i,
    output pkg_ready_o, deq_valid_o, deq_o, count_o
  );

  modport master (
    output flush_i, pkg_valid_i, pkg_mask_i, pkg_i, deq_ready_i,
    input  pkg_ready_o, deq_valid_o, deq_o, count_o
  );
endinterface

// File: rtl/wired_inst_queue.sv
// Multi-lane instruction decoupling queue: compacts masked packages into a
// circular buffer and presents the oldest DEQ entries to the decoder.
module wired_inst_queue #(
  parameter int unsigned LANES      = 2,
  parameter int unsigned DEQ        = 2,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  wired_inst_queue_if.slave q
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;

  logic                  pkg_ready;
  logic                  enq_fire;
  logic [CW-1:0]         lanes_set;
  logic [PW-1:0]         wr_off [LANES];
  logic [CW-1:0]         enq_n;
  logic [CW-1:0]         deq_m;
  logic                  run;
  logic [DEQ-1:0]        deq_valid;
  logic [DEQ-1:0][DATA_WIDTH-1:0] deq_data;

  assign pkg_ready = (count <= CW'(DEPTH - LANES));
  assign enq_fire  = q.pkg_valid_i & pkg_ready & ~q.flush_i;

  // Compaction: each set lane lands at tail + (number of set lanes below it)
  always_comb begin
    lanes_set = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_off[i] = PW'(lanes_set);
      lanes_set = lanes_set + CW'(q.pkg_mask_i[i]);
    end
    enq_n = enq_fire ? lanes_set : '0;
  end

  always_comb begin
    deq_valid = '0;
    deq_data  = '0;
    for (int k = 0; k < DEQ; k++) begin
      deq_valid[k] = (CW'(k) < count);
      if (deq_valid[k]) deq_data[k] = mem[head + PW'(k)];
    end
  end

  // Only the leading run of accepted slots retires, so gaps never drop entries
  always_comb begin
    deq_m = '0;
    run   = 1'b1;
    for (int k = 0; k < DEQ; k++) begin
      run   = run & q.deq_ready_i[k] & deq_valid[k];
      deq_m = deq_m + CW'(run);
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int i = 0; i < LANES; i++) begin
        if (q.pkg_mask_i[i]) mem[tail + wr_off[i]] <= q.pkg_i[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (q.flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq_m);
      tail  <= tail + PW'(enq_n);
      count <= count + enq_n - deq_m;
    end
  end

  assign q.pkg_ready_o = pkg_ready;
  assign q.deq_valid_o = deq_valid;
  assign q.deq_o       = deq_data;
  assign q.count_o     = count;
endmodule
